// File: rtl/wb_tdp_bram_pkg.sv
// Shared types and constants for the dual-port Wishbone block RAM.
package wb_tdp_bram_pkg;

    localparam int WORD_WIDTH     = 8;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int MAX_ADDR_WIDTH = 16;

    typedef logic [WORD_WIDTH-1:0] word_t;

    // Addresses are carried zero-extended to MAX_ADDR_WIDTH; each port narrows back.
    typedef struct packed {
        logic                      cyc;
        logic                      stb;
        logic                      we;
        logic [MAX_ADDR_WIDTH-1:0] addr;
        word_t                     data;
    } port_req_t;

endpackage

// File: rtl/wb_tdp_bram_port.sv
// One Wishbone pipelined slave port: request accept, write strobe, ack and read-data registers.
module wb_tdp_bram_port
    import wb_tdp_bram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  port_req_t             req,
    input  word_t                 rd_word,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] addr,
    output word_t                 wr_data,
    output logic                  ack,
    output word_t                 data_out
);

    logic  accept;
    logic  vld_p1;
    word_t rdata_p1;

    // Reset blocks acceptance, so no write lands and no ack is scheduled.
    assign accept  = req.cyc & req.stb & ~reset;
    assign wr_en   = accept & req.we;
    assign addr    = req.addr[ADDR_WIDTH-1:0];
    assign wr_data = req.data;

    if (ADDR_WIDTH < MAX_ADDR_WIDTH) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = |req.addr[MAX_ADDR_WIDTH-1:ADDR_WIDTH];
    end

    // Stage p1: ack and read data, registered at the accepting edge.
    // rd_word is the pre-edge array content, which gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1   <= 1'b0;
            rdata_p1 <= '0;
        end else begin
            vld_p1 <= accept;
            if (accept && !req.we) begin
                rdata_p1 <= rd_word;
            end
        end
    end

    assign ack      = vld_p1;
    assign data_out = rdata_p1;

endmodule

// File: rtl/wb_tdp_bram.sv
// True dual-port 8-bit block RAM with two Wishbone B4 pipelined slave ports sharing one array.
module wb_tdp_bram
    import wb_tdp_bram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = WORD_WIDTH,
    parameter int INIT_ZERO  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_cyc,
    input  logic                  a_stb,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data_in,
    output logic [DATA_WIDTH-1:0] a_data_out,
    output logic                  a_ack,
    output logic                  a_stall,
    input  logic                  b_cyc,
    input  logic                  b_stb,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_data_in,
    output logic [DATA_WIDTH-1:0] b_data_out,
    output logic                  b_ack,
    output logic                  b_stall
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    word_t mem [DEPTH] = '{default: (INIT_ZERO != 0) ? {WORD_WIDTH{1'b0}} : {WORD_WIDTH{1'bx}}};

    port_req_t             a_req, b_req;
    logic                  a_wr_en, b_wr_en;
    logic [ADDR_WIDTH-1:0] a_word_addr, b_word_addr;
    word_t                 a_wr_data, b_wr_data;
    word_t                 a_rd_word, b_rd_word;
    logic                  b_wr_ok;

    assign a_req = '{cyc: a_cyc, stb: a_stb, we: a_we,
                     addr: MAX_ADDR_WIDTH'(a_addr), data: a_data_in};
    assign b_req = '{cyc: b_cyc, stb: b_stb, we: b_we,
                     addr: MAX_ADDR_WIDTH'(b_addr), data: b_data_in};

    assign a_rd_word = mem[a_word_addr];
    assign b_rd_word = mem[b_word_addr];

    wb_tdp_bram_port #(.ADDR_WIDTH(ADDR_WIDTH)) u_port_a (
        .clk      (clk),
        .reset    (reset),
        .req      (a_req),
        .rd_word  (a_rd_word),
        .wr_en    (a_wr_en),
        .addr     (a_word_addr),
        .wr_data  (a_wr_data),
        .ack      (a_ack),
        .data_out (a_data_out)
    );

    wb_tdp_bram_port #(.ADDR_WIDTH(ADDR_WIDTH)) u_port_b (
        .clk      (clk),
        .reset    (reset),
        .req      (b_req),
        .rd_word  (b_rd_word),
        .wr_en    (b_wr_en),
        .addr     (b_word_addr),
        .wr_data  (b_wr_data),
        .ack      (b_ack),
        .data_out (b_data_out)
    );

    // Port A owns the word when both ports write the same address in one cycle.
    assign b_wr_ok = b_wr_en & ~(a_wr_en && (a_word_addr == b_word_addr));

    // Stage p0 -> array: writes land at the accepting edge.
    always_ff @(posedge clk) begin
        if (a_wr_en) begin
            mem[a_word_addr] <= a_wr_data;
        end
        if (b_wr_ok) begin
            mem[b_word_addr] <= b_wr_data;
        end
    end

    assign a_stall = 1'b0;
    assign b_stall = 1'b0;

endmodule

// File: tb/tb_wb_tdp_bram.sv
// Bench for wb_tdp_bram: directed scenarios plus random traffic against an array reference model.
module tb_wb_tdp_bram;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_cyc, a_stb, a_we, b_cyc, b_stb, b_we;
    logic [7:0] a_addr, a_data_in, b_addr, b_data_in;
    logic [7:0] a_data_out, b_data_out;
    logic       a_ack, a_stall, b_ack, b_stall;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] ref_mem [256];
    logic       ea_ack, eb_ack;
    logic [7:0] ea_dat, eb_dat;

    wb_tdp_bram #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .INIT_ZERO(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .a_cyc      (a_cyc),
        .a_stb      (a_stb),
        .a_we       (a_we),
        .a_addr     (a_addr),
        .a_data_in  (a_data_in),
        .a_data_out (a_data_out),
        .a_ack      (a_ack),
        .a_stall    (a_stall),
        .b_cyc      (b_cyc),
        .b_stb      (b_stb),
        .b_we       (b_we),
        .b_addr     (b_addr),
        .b_data_in  (b_data_in),
        .b_data_out (b_data_out),
        .b_ack      (b_ack),
        .b_stall    (b_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic drive_a(input logic cyc, input logic stb, input logic we,
                           input logic [7:0] addr, input logic [7:0] data);
        a_cyc = cyc; a_stb = stb; a_we = we; a_addr = addr; a_data_in = data;
    endtask

    task automatic drive_b(input logic cyc, input logic stb, input logic we,
                           input logic [7:0] addr, input logic [7:0] data);
        b_cyc = cyc; b_stb = stb; b_we = we; b_addr = addr; b_data_in = data;
    endtask

    // Advance one clock: predict from the current inputs, then check after the edge.
    task automatic step();
        logic a_acc, b_acc;
        a_acc = a_cyc && a_stb;
        b_acc = b_cyc && b_stb;
        if (reset) begin
            ea_ack = 1'b0; eb_ack = 1'b0;
            ea_dat = 8'h00; eb_dat = 8'h00;
        end else begin
            ea_ack = a_acc;
            eb_ack = b_acc;
            if (a_acc && !a_we) ea_dat = ref_mem[a_addr];
            if (b_acc && !b_we) eb_dat = ref_mem[b_addr];
            if (b_acc && b_we) ref_mem[b_addr] = b_data_in;
            if (a_acc && a_we) ref_mem[a_addr] = a_data_in;
        end
        @(posedge clk);
        #1;
        chk("a_ack", {7'b0, a_ack}, {7'b0, ea_ack});
        chk("b_ack", {7'b0, b_ack}, {7'b0, eb_ack});
        chk("a_data_out", a_data_out, ea_dat);
        chk("b_data_out", b_data_out, eb_dat);
        chk("a_stall", {7'b0, a_stall}, 8'h00);
        chk("b_stall", {7'b0, b_stall}, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        ea_ack = 1'b0; eb_ack = 1'b0; ea_dat = 8'h00; eb_dat = 8'h00;

        // Reset held with a write request pending on A.
        reset = 1'b1;
        drive_a(1, 1, 1, 8'h10, 8'h55);
        drive_b(0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_a_ack", {7'b0, a_ack}, 8'h00);
            chk("rst_a_data", a_data_out, 8'h00);
        end
        reset = 1'b0;
        drive_a(0, 0, 0, 8'h00, 8'h00);
        step();
        drive_a(1, 1, 0, 8'h10, 8'h00);
        step();
        chk("rst_keep_mem", a_data_out, 8'h00);

        // stb without cyc is ignored.
        drive_a(0, 1, 1, 8'h10, 8'h77);
        step();
        chk("stb_no_cyc_ack", {7'b0, a_ack}, 8'h00);

        // Single-port write then read.
        drive_a(1, 1, 1, 8'h03, 8'hA5);
        step();
        chk("sp_wr_ack", {7'b0, a_ack}, 8'h01);
        drive_a(1, 1, 0, 8'h03, 8'h00);
        step();
        chk("sp_rd_ack", {7'b0, a_ack}, 8'h01);
        chk("sp_rd_data", a_data_out, 8'hA5);

        // Cross-port read-first.
        drive_b(1, 1, 1, 8'h7F, 8'h3C);
        drive_a(1, 1, 0, 8'h7F, 8'h00);
        step();
        chk("xp_old", a_data_out, 8'h00);
        drive_b(0, 0, 0, 8'h00, 8'h00);
        step();
        chk("xp_new", a_data_out, 8'h3C);

        // Same-address write collision: A wins, both acked.
        drive_a(1, 1, 1, 8'h40, 8'h11);
        drive_b(1, 1, 1, 8'h40, 8'h22);
        step();
        chk("col_a_ack", {7'b0, a_ack}, 8'h01);
        chk("col_b_ack", {7'b0, b_ack}, 8'h01);
        drive_a(1, 1, 0, 8'h40, 8'h00);
        drive_b(1, 1, 0, 8'h40, 8'h00);
        step();
        chk("col_a_rd", a_data_out, 8'h11);
        chk("col_b_rd", b_data_out, 8'h11);
        drive_b(0, 0, 0, 8'h00, 8'h00);

        // Streaming writes then concurrent forward/reverse reads.
        for (int i = 0; i < 256; i++) begin
            drive_a(1, 1, 1, 8'(i), 8'(i));
            step();
            chk("st_wr_ack", {7'b0, a_ack}, 8'h01);
        end
        for (int i = 0; i < 256; i++) begin
            drive_a(1, 1, 0, 8'(i), 8'h00);
            drive_b(1, 1, 0, 8'(255 - i), 8'h00);
            step();
            chk("st_a_rd", a_data_out, 8'(i));
            chk("st_b_rd", b_data_out, 8'(255 - i));
        end
        drive_b(0, 0, 0, 8'h00, 8'h00);

        // Reset in the ack cycle of a read.
        drive_a(1, 1, 0, 8'h05, 8'h00);
        step();
        chk("mid_ack", {7'b0, a_ack}, 8'h01);
        chk("mid_data", a_data_out, 8'h05);
        drive_a(0, 0, 0, 8'h00, 8'h00);
        reset = 1'b1;
        step();
        chk("mid_rst_ack", {7'b0, a_ack}, 8'h00);
        chk("mid_rst_data", a_data_out, 8'h00);
        reset = 1'b0;

        // Random traffic on a narrow address window to force collisions.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] aa, ba;
            aa = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            ba = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            drive_a(1'($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom), aa, 8'($urandom));
            drive_b(1'($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom), ba, 8'($urandom));
            reset = ($urandom_range(0, 31) == 0);
            step();
        end
        reset = 1'b0;
        drive_a(0, 0, 0, 8'h00, 8'h00);
        drive_b(0, 0, 0, 8'h00, 8'h00);

        // Final sweep of the array through port B.
        for (int i = 0; i < 256; i++) begin
            drive_b(1, 1, 0, 8'(i), 8'h00);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
